// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage main decoder: opcodes, select enums and the
// reset/nop control word.
package ctrl_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpCsr    = 7'b1110011;

    localparam logic [31:0] NopInst = 32'h0000_0013;

    typedef enum logic [2:0] {
        ImmI   = 3'd0,
        ImmS   = 3'd1,
        ImmB   = 3'd2,
        ImmU   = 3'd3,
        ImmJ   = 3'd4,
        ImmCsr = 3'd5
    } imm_sel_e;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_sel_e;

    typedef enum logic [1:0] {
        WbMem = 2'd0,
        WbAlu = 2'd1,
        WbPc4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        imm_sel_e   imm_sel;
        logic       br_un;
        alu_sel_e   alu_sel;
        logic [3:0] mem_wen;
        logic       csr_src;
        logic [2:0] ld_sel;
        wb_sel_e    wb_sel;
        logic       reg_wen;
    } ctrl_t;

    localparam ctrl_t CtrlReset = '{
        imm_sel: ImmI,
        br_un:   1'b0,
        alu_sel: AluAdd,
        mem_wen: 4'b0000,
        csr_src: 1'b0,
        ld_sel:  3'b010,
        wb_sel:  WbAlu,
        reg_wen: 1'b0
    };

    // alt selects SUB for funct3=000 and SRA for funct3=101; ignored otherwise.
    function automatic alu_sel_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_sel_e sel;
        case (funct3)
            3'b000:  sel = alt ? AluSub : AluAdd;
            3'b001:  sel = AluSll;
            3'b010:  sel = AluSlt;
            3'b011:  sel = AluSltu;
            3'b100:  sel = AluXor;
            3'b101:  sel = alt ? AluSra : AluSrl;
            3'b110:  sel = AluOr;
            default: sel = AluAnd;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I (+csrw/csrwi) main decoder: instruction word to datapath selects.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       rd_nz;
    logic       unused_bits;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign alt         = inst_i[30];
    assign rd_nz       = (inst_i[11:7] != 5'd0);
    assign unused_bits = ^{inst_i[31], inst_i[29:15]};

    always_comb begin
        ctrl_o = CtrlReset;
        case (opcode)
            OpLui: begin
                ctrl_o.imm_sel = ImmU;
                ctrl_o.alu_sel = AluPassB;
                ctrl_o.reg_wen = 1'b1;
            end
            OpAuipc: begin
                ctrl_o.imm_sel = ImmU;
                ctrl_o.reg_wen = 1'b1;
            end
            OpJal: begin
                ctrl_o.imm_sel = ImmJ;
                ctrl_o.wb_sel  = WbPc4;
                ctrl_o.reg_wen = 1'b1;
            end
            OpJalr: begin
                ctrl_o.wb_sel  = WbPc4;
                ctrl_o.reg_wen = 1'b1;
            end
            OpBranch: begin
                ctrl_o.imm_sel = ImmB;
                ctrl_o.br_un   = inst_i[13];
            end
            OpLoad: begin
                ctrl_o.ld_sel  = funct3;
                ctrl_o.wb_sel  = WbMem;
                ctrl_o.reg_wen = 1'b1;
            end
            OpStore: begin
                ctrl_o.imm_sel = ImmS;
                case (funct3[1:0])
                    2'b00:   ctrl_o.mem_wen = 4'b0001;
                    2'b01:   ctrl_o.mem_wen = 4'b0011;
                    2'b10:   ctrl_o.mem_wen = 4'b1111;
                    default: ctrl_o.mem_wen = 4'b0000;
                endcase
            end
            OpImm: begin
                // inst[30] is immediate data except for the shift-right pair.
                ctrl_o.alu_sel = alu_from_funct3(funct3, alt && (funct3 == 3'b101));
                ctrl_o.reg_wen = 1'b1;
            end
            OpReg: begin
                ctrl_o.alu_sel = alu_from_funct3(funct3, alt);
                ctrl_o.reg_wen = 1'b1;
            end
            OpCsr: begin
                if (funct3 == 3'b101) begin
                    ctrl_o.imm_sel = ImmCsr;
                    ctrl_o.csr_src = 1'b1;
                end
            end
            default: ctrl_o = CtrlReset;
        endcase
        ctrl_o.reg_wen = ctrl_o.reg_wen && rd_nz;
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage control unit: decodes inst and registers the control word plus the
// instruction into the ID/EX boundary.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [2:0]  ImmSel,
    output logic        BrUn,
    output logic [3:0]  ALUSel,
    output logic [3:0]  MEMWen,
    output logic        CSRSrc,
    output logic [2:0]  LDSel,
    output logic [1:0]  WBSel,
    output logic        RegWen,
    output logic [31:0] Inst
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_q;
    logic [31:0] inst_q;

    ctrl_decode u_decode (
        .inst_i (inst),
        .ctrl_o (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= CtrlReset;
            inst_q <= NopInst;
        end else begin
            ctrl_q <= ctrl_d;
            inst_q <= inst;
        end
    end

    assign ImmSel = ctrl_q.imm_sel;
    assign BrUn   = ctrl_q.br_un;
    assign ALUSel = ctrl_q.alu_sel;
    assign MEMWen = ctrl_q.mem_wen;
    assign CSRSrc = ctrl_q.csr_src;
    assign LDSel  = ctrl_q.ld_sel;
    assign WBSel  = ctrl_q.wb_sel;
    assign RegWen = ctrl_q.reg_wen;
    assign Inst   = inst_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset corner sequences and a
// randomized run against a mnemonic-level reference model.
module tb_control_unit;

    typedef struct packed {
        logic [2:0]  imm;
        logic        brun;
        logic [3:0]  alu;
        logic [3:0]  mem;
        logic        csr;
        logic [2:0]  ld;
        logic [1:0]  wb;
        logic        rw;
        logic [31:0] inst;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [2:0]  ImmSel;
    logic        BrUn;
    logic [3:0]  ALUSel;
    logic [3:0]  MEMWen;
    logic        CSRSrc;
    logic [2:0]  LDSel;
    logic [1:0]  WBSel;
    logic        RegWen;
    logic [31:0] Inst;

    int n_tests;
    int n_fail;

    control_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .inst   (inst),
        .ImmSel (ImmSel),
        .BrUn   (BrUn),
        .ALUSel (ALUSel),
        .MEMWen (MEMWen),
        .CSRSrc (CSRSrc),
        .LDSel  (LDSel),
        .WBSel  (WBSel),
        .RegWen (RegWen),
        .Inst   (Inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [31:0] i, input int imm, input int brun,
                                input int alu, input int mem, input int csr, input int ld,
                                input int wb, input int rw);
        out_t o;
        o.imm  = 3'(imm);
        o.brun = 1'(brun);
        o.alu  = 4'(alu);
        o.mem  = 4'(mem);
        o.csr  = 1'(csr);
        o.ld   = 3'(ld);
        o.wb   = 2'(wb);
        o.rw   = 1'(rw);
        o.inst = i;
        return o;
    endfunction

    function automatic out_t reset_out();
        return mk(32'h0000_0013, 0, 0, 0, 0, 0, 2, 1, 0);
    endfunction

    // Reference model: classify by mnemonic group, then fill fields arithmetically.
    function automatic out_t model(input logic [31:0] i);
        int alu_of_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int f3    = int'(i[14:12]);
        int op    = int'(i[6:0]);
        int imm   = 0;
        int brun  = 0;
        int alu   = 0;
        int mem   = 0;
        int csr   = 0;
        int ld    = 2;
        int wb    = 1;
        int wr    = 0;
        case (op)
            'h37: begin imm = 3; alu = 10; wr = 1; end
            'h17: begin imm = 3; wr = 1; end
            'h6f: begin imm = 4; wb = 2; wr = 1; end
            'h67: begin wb = 2; wr = 1; end
            'h63: begin imm = 2; brun = f3 / 2 % 2; end
            'h03: begin ld = f3; wb = 0; wr = 1; end
            'h23: begin
                imm = 1;
                mem = (f3 % 4 < 3) ? (1 << (1 << (f3 % 4))) - 1 : 0;
            end
            'h13: begin alu = alu_of_f3[f3] + ((f3 == 5 && i[30]) ? 1 : 0); wr = 1; end
            'h33: begin
                alu = alu_of_f3[f3] + (((f3 == 0 || f3 == 5) && i[30]) ? 1 : 0);
                wr = 1;
            end
            'h73: begin
                if (f3 == 5) begin imm = 5; csr = 1; end
            end
            default: ;
        endcase
        if (i[11:7] == 5'd0) wr = 0;
        return mk(i, imm, brun, alu, mem, csr, ld, wb, wr);
    endfunction

    function automatic out_t sample();
        out_t o;
        o.imm  = ImmSel;
        o.brun = BrUn;
        o.alu  = ALUSel;
        o.mem  = MEMWen;
        o.csr  = CSRSrc;
        o.ld   = LDSel;
        o.wb   = WBSel;
        o.rw   = RegWen;
        o.inst = Inst;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = sample();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got imm=%0d brun=%0d alu=%0d mem=%b csr=%0d ld=%b wb=%0d rw=%0d inst=%h ; want imm=%0d brun=%0d alu=%0d mem=%b csr=%0d ld=%b wb=%0d rw=%0d inst=%h",
                     name, got.imm, got.brun, got.alu, got.mem, got.csr, got.ld, got.wb,
                     got.rw, got.inst, exp.imm, exp.brun, exp.alu, exp.mem, exp.csr, exp.ld,
                     exp.wb, exp.rw, exp.inst);
        end
    endtask

    // Drive away from the active edge, sample 1 time unit after it.
    task automatic apply(input logic rst_val, input logic [31:0] i);
        @(negedge clk);
        rst_n = rst_val;
        inst  = i;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        inst    = 32'h004d_22b7;

        vecs.push_back('{"lui",    32'h004d22b7, mk(32'h004d22b7, 3, 0, 10, 0, 0, 2, 1, 1)});
        vecs.push_back('{"jal",    32'h000003ef, mk(32'h000003ef, 4, 0, 0, 0, 0, 2, 2, 1)});
        vecs.push_back('{"bltu",   32'h0666ee63, mk(32'h0666ee63, 2, 1, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"lh",     32'h00849803, mk(32'h00849803, 0, 0, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"sb",     32'h01468423, mk(32'h01468423, 1, 0, 0, 1, 0, 2, 1, 0)});
        vecs.push_back('{"sh",     32'h01571423, mk(32'h01571423, 1, 0, 0, 3, 0, 2, 1, 0)});
        vecs.push_back('{"sw",     32'h0167a423, mk(32'h0167a423, 1, 0, 0, 15, 0, 2, 1, 0)});
        vecs.push_back('{"addi30", 32'hfce80b93, mk(32'hfce80b93, 0, 0, 0, 0, 0, 2, 1, 1)});
        vecs.push_back('{"srai",   32'h410c5f93, mk(32'h410c5f93, 0, 0, 7, 0, 0, 2, 1, 1)});
        vecs.push_back('{"sub",    32'h402d00b3, mk(32'h402d00b3, 0, 0, 1, 0, 0, 2, 1, 1)});
        vecs.push_back('{"and",    32'h00a174b3, mk(32'h00a174b3, 0, 0, 9, 0, 0, 2, 1, 1)});
        vecs.push_back('{"csrw",   32'h51e51073, mk(32'h51e51073, 0, 0, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"csrwi",  32'h51e0d073, mk(32'h51e0d073, 5, 0, 0, 0, 1, 2, 1, 0)});
        vecs.push_back('{"lui_x0", 32'h004d2037, mk(32'h004d2037, 3, 0, 10, 0, 0, 2, 1, 0)});
        vecs.push_back('{"unknwn", 32'hffff_ffff, mk(32'hffff_ffff, 0, 0, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"bgeu",   32'h00b57463, mk(32'h00b57463, 2, 1, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"blt",    32'h00b54463, mk(32'h00b54463, 2, 0, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"st_f11", 32'h00b53423, mk(32'h00b53423, 1, 0, 0, 0, 0, 2, 1, 0)});
        vecs.push_back('{"sra",    32'h40b55533, mk(32'h40b55533, 0, 0, 7, 0, 0, 2, 1, 1)});
        vecs.push_back('{"jalr",   32'h000500e7, mk(32'h000500e7, 0, 0, 0, 0, 0, 2, 2, 1)});
        vecs.push_back('{"auipc",  32'h00001517, mk(32'h00001517, 3, 0, 0, 0, 0, 2, 1, 1)});

        // Reset wins over a valid instruction on the input.
        apply(1'b0, 32'h004d22b7);
        check("reset", reset_out());

        foreach (vecs[k]) begin
            apply(1'b1, vecs[k].inst);
            check(vecs[k].name, vecs[k].exp);
        end

        // Mid-stream reset, then recovery with the same instruction.
        apply(1'b1, 32'h00849803);
        check("pre_rst_lh", mk(32'h00849803, 0, 0, 0, 0, 0, 1, 0, 1));
        apply(1'b0, 32'h0167a423);
        check("midrst", reset_out());
        apply(1'b1, 32'h0167a423);
        check("post_rst_sw", mk(32'h0167a423, 1, 0, 0, 15, 0, 2, 1, 0));

        // Back-to-back: each edge reflects only the instruction presented before it.
        apply(1'b1, 32'h402d00b3);
        check("b2b_sub", mk(32'h402d00b3, 0, 0, 1, 0, 0, 2, 1, 1));
        apply(1'b1, 32'h51e0d073);
        check("b2b_csrwi", mk(32'h51e0d073, 5, 0, 0, 0, 1, 2, 1, 0));

        for (int n = 0; n < 400; n++) begin
            logic [6:0]  ops [11];
            logic [31:0] r;
            logic        do_rst;
            ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73,
                    7'h00};
            r = $urandom;
            if ($urandom_range(0, 10) != 10) r[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
            do_rst = ($urandom_range(0, 15) == 0);
            apply(!do_rst, r);
            check(do_rst ? "rand_rst" : "rand", do_rst ? reset_out() : model(r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
